mc_ctrl_ws: RTL and testbench

Parametrised multicycle MIPS control unit with memory wait-state handshake, a watchdog timeout, illegal-opcode trapping and a retired-instruction counter. It drives the same datapath select and enable signals as the current multicycle controller. It also stalls the FETCH and MEM phases until the shared instruction/data memory asserts `mem_ready`. It sits between the instruction register and the multicycle datapath (PC, IR, MDR, register file, ALU, extender).

---
 rtl/mc_ctrl_ws_if.sv | 41 ++++
 rtl/mc_ctrl_ws.sv | 208 ++++++++++++++++++++
 tb/tb_mc_ctrl_ws.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_ws_if.sv
// Control bus between the multicycle controller and the datapath/memory.
// The controller drives selects/enables; the datapath supplies IR contents and memory ready.
interface mc_ctrl_ws_if #(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 32
);
  logic [31:0]        instr;
  logic               mem_ready;
  logic               mem_req;
  logic [1:0]         IorD_o;
  logic               PCWrite_o;
  logic               PCWriteCond_o;
  logic               MemWrite_o;
  logic               IRWrite_o;
  logic [1:0]         MemtoReg_o;
  logic [1:0]         PCSrc_o;
  logic [ALUOP_W-1:0] ALUOp_o;
  logic [1:0]         ALUSrcA_o;
  logic [1:0]         ALUSrcB_o;
  logic               RegWrite_o;
  logic [1:0]         RegDst_o;
  logic [1:0]         EXTOp_o;
  logic               trap_o;
  logic [1:0]         trap_code_o;
  logic [CNT_W-1:0]   retired_o;
  logic [3:0]         state_o;

  modport master (
    input  instr, mem_ready,
    output mem_req, IorD_o, PCWrite_o, PCWriteCond_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, PCSrc_o, ALUOp_o, ALUSrcA_o, ALUSrcB_o, RegWrite_o,
           RegDst_o, EXTOp_o, trap_o, trap_code_o, retired_o, state_o
  );

  modport slave (
    output instr, mem_ready,
    input  mem_req, IorD_o, PCWrite_o, PCWriteCond_o, MemWrite_o, IRWrite_o,
           MemtoReg_o, PCSrc_o, ALUOp_o, ALUSrcA_o, ALUSrcB_o, RegWrite_o,
           RegDst_o, EXTOp_o, trap_o, trap_code_o, retired_o, state_o
  );
endinterface

// File: rtl/mc_ctrl_ws.sv
// Multicycle MIPS controller with memory wait states, access watchdog,
// illegal-instruction trap and retired-instruction counter.
module mc_ctrl_ws #(
  parameter int ALUOP_W = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic          clk,
  input  logic          rst,
  mc_ctrl_ws_if.master  bus
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2, S_MEM = 4'd3, S_WB_MEM = 4'd4,
    S_EXEC = 4'd5, S_WB_ALU = 4'd6, S_BRANCH = 4'd7, S_JUMP = 4'd8, S_LINK = 4'd9,
    S_TRAP = 4'd15
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0),  ALU_SUB  = ALUOP_W'(1),
                                 ALU_AND  = ALUOP_W'(2),  ALU_OR   = ALUOP_W'(3),
                                 ALU_XOR  = ALUOP_W'(4),  ALU_NOR  = ALUOP_W'(5),
                                 ALU_SLT  = ALUOP_W'(6),  ALU_SLTU = ALUOP_W'(7),
                                 ALU_SLL  = ALUOP_W'(8),  ALU_SRL  = ALUOP_W'(9),
                                 ALU_SRA  = ALUOP_W'(10), ALU_SLLV = ALUOP_W'(11),
                                 ALU_SRLV = ALUOP_W'(12), ALU_SRAV = ALUOP_W'(13),
                                 ALU_LUI  = ALUOP_W'(14), ALU_BNE  = ALUOP_W'(15),
                                 ALU_BLEZ = ALUOP_W'(16), ALU_BGTZ = ALUOP_W'(17),
                                 ALU_BLTZ = ALUOP_W'(18), ALU_BGEZ = ALUOP_W'(19);
  localparam logic [1:0] EXT_ZERO = 2'b00, EXT_SIGN = 2'b01;
  localparam logic [1:0] TC_NONE = 2'b00, TC_ILL = 2'b01, TC_TMO = 2'b10;
  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [1:0]          tcode_q, tcode_d;
  logic [CNT_W-1:0]    ret_q, ret_d;

  logic [5:0] op, fn;
  logic [4:0] rt;
  assign op = bus.instr[31:26];
  assign fn = bus.instr[5:0];
  assign rt = bus.instr[20:16];
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[25:21], bus.instr[15:6]};

  logic is_r, is_jr, is_jalr, is_load, is_store, is_br, is_j, is_jal;
  assign is_r     = (op == 6'h00);
  assign is_jr    = is_r && (fn == 6'h08);
  assign is_jalr  = is_r && (fn == 6'h09);
  assign is_load  = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
  assign is_store = (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  assign is_br    = (op == 6'h01) || (op >= 6'h04 && op <= 6'h07);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);

  logic r_alu, r_shamt, i_alu;
  logic [ALUOP_W-1:0] r_op, i_op;
  always_comb begin
    r_alu = 1'b1; r_shamt = 1'b0; r_op = ALU_ADD;
    unique case (fn)
      6'h20, 6'h21: r_op = ALU_ADD;
      6'h22, 6'h23: r_op = ALU_SUB;
      6'h24: r_op = ALU_AND;
      6'h25: r_op = ALU_OR;
      6'h26: r_op = ALU_XOR;
      6'h27: r_op = ALU_NOR;
      6'h2A: r_op = ALU_SLT;
      6'h2B: r_op = ALU_SLTU;
      6'h00: begin r_op = ALU_SLL; r_shamt = 1'b1; end
      6'h02: begin r_op = ALU_SRL; r_shamt = 1'b1; end
      6'h03: begin r_op = ALU_SRA; r_shamt = 1'b1; end
      6'h04: r_op = ALU_SLLV;
      6'h06: r_op = ALU_SRLV;
      6'h07: r_op = ALU_SRAV;
      default: r_alu = 1'b0;
    endcase
    i_alu = 1'b1; i_op = ALU_ADD;
    unique case (op)
      6'h08, 6'h09: i_op = ALU_ADD;
      6'h0A: i_op = ALU_SLT;
      6'h0B: i_op = ALU_SLTU;
      6'h0C: i_op = ALU_AND;
      6'h0D: i_op = ALU_OR;
      6'h0E: i_op = ALU_XOR;
      6'h0F: i_op = ALU_LUI;
      default: i_alu = 1'b0;
    endcase
  end

  // Watchdog fires on the cycle the wait count reaches TIMEOUT with memory still busy.
  logic timeout;
  assign timeout = (TIMEOUT > 0) && (wcnt_q == WCNT_W'(TIMEOUT)) && !bus.mem_ready;

  logic pcw, pcwc, memw, irw, regw, req;
  logic [1:0] iord, m2r, pcsrc, srca, srcb, rdst;
  logic [ALUOP_W-1:0] aluop;

  always_comb begin
    state_d = state_q;
    pcw = 1'b0; pcwc = 1'b0; memw = 1'b0; irw = 1'b0; regw = 1'b0; req = 1'b0;
    iord = 2'b00; m2r = 2'b00; pcsrc = 2'b00; srca = 2'b00; srcb = 2'b01; rdst = 2'b00;
    aluop = ALU_ADD;
    unique case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (timeout) state_d = S_TRAP;
        else if (bus.mem_ready) begin pcw = 1'b1; irw = 1'b1; state_d = S_DECODE; end
      end
      S_DECODE: begin
        srcb = 2'b11;
        if (is_load || is_store)                          state_d = S_ADDR;
        else if ((is_r && (r_alu || is_jr)) || i_alu)     state_d = S_EXEC;
        else if (is_br)                                   state_d = S_BRANCH;
        else if (is_j)                                    state_d = S_JUMP;
        else if (is_jal || is_jalr)                       state_d = S_LINK;
        else                                              state_d = S_TRAP;
      end
      S_ADDR: begin srca = 2'b01; srcb = 2'b10; state_d = S_MEM; end
      S_MEM: begin
        req = 1'b1; iord = 2'b01;
        if (timeout) state_d = S_TRAP;
        else begin
          memw = is_store;
          if (bus.mem_ready) state_d = is_store ? S_FETCH : S_WB_MEM;
        end
      end
      S_WB_MEM: begin regw = 1'b1; m2r = 2'b01; state_d = S_FETCH; end
      S_EXEC: begin
        if (is_r) begin
          srcb = 2'b00;
          srca = r_shamt ? 2'b10 : 2'b01;
          aluop = (is_jr || is_jalr) ? ALU_ADD : r_op;
          state_d = (is_jr || is_jalr) ? S_JUMP : S_WB_ALU;
        end else begin
          srca = 2'b01; srcb = 2'b10; aluop = i_op; state_d = S_WB_ALU;
        end
      end
      S_WB_ALU: begin regw = 1'b1; rdst = is_r ? 2'b01 : 2'b00; state_d = S_FETCH; end
      S_LINK: begin
        regw = 1'b1; m2r = 2'b10;
        rdst = is_jal ? 2'b10 : 2'b01;
        state_d = is_jal ? S_JUMP : S_EXEC;
      end
      S_BRANCH: begin
        pcwc = 1'b1; pcsrc = 2'b01; srca = 2'b01; srcb = 2'b00;
        unique case (op)
          6'h05:   aluop = ALU_BNE;
          6'h06:   aluop = ALU_BLEZ;
          6'h07:   aluop = ALU_BGTZ;
          6'h01:   aluop = (rt == 5'd0) ? ALU_BLTZ : ALU_BGEZ;
          default: aluop = ALU_SUB;
        endcase
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcw = 1'b1; pcsrc = (is_j || is_jal) ? 2'b10 : 2'b01; state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wcnt_d = '0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready && !timeout)
      wcnt_d = wcnt_q + 1'b1;
    tcode_d = tcode_q;
    if (state_d == S_TRAP && state_q != S_TRAP)
      tcode_d = (state_q == S_DECODE) ? TC_ILL : TC_TMO;
    ret_d = ret_q;
    if (state_d == S_FETCH && state_q != S_FETCH)
      ret_d = ret_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      wcnt_q  <= '0;
      tcode_q <= TC_NONE;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcode_q <= tcode_d;
      ret_q   <= ret_d;
    end
  end

  // Reset is asynchronous, so enables are also masked combinationally while it is held.
  assign bus.mem_req       = req  & ~rst;
  assign bus.PCWrite_o     = pcw  & ~rst;
  assign bus.PCWriteCond_o = pcwc & ~rst;
  assign bus.MemWrite_o    = memw & ~rst;
  assign bus.IRWrite_o     = irw  & ~rst;
  assign bus.RegWrite_o    = regw & ~rst;
  assign bus.IorD_o        = iord;
  assign bus.MemtoReg_o    = m2r;
  assign bus.PCSrc_o       = pcsrc;
  assign bus.ALUOp_o       = aluop;
  assign bus.ALUSrcA_o     = srca;
  assign bus.ALUSrcB_o     = srcb;
  assign bus.RegDst_o      = rdst;
  assign bus.EXTOp_o       = (op == 6'h08 || op == 6'h09 || op == 6'h0A || is_br || is_load || is_store)
                             ? EXT_SIGN : EXT_ZERO;
  assign bus.trap_o        = (state_q == S_TRAP);
  assign bus.trap_code_o   = tcode_q;
  assign bus.retired_o     = ret_q;
  assign bus.state_o       = state_q;
endmodule

// File: tb/tb_mc_ctrl_ws.sv
// Scoreboard bench for mc_ctrl_ws: per-cycle expectations queued at drive time, popped at negedge.
module tb_mc_ctrl_ws;
  localparam int AW = 5, CW = 32;
  localparam logic [4:0] PC = 5'b10000, PCC = 5'b01000, IR = 5'b00100, MW = 5'b00010,
                         RW = 5'b00001, NO = 5'b00000;
  localparam int ADD = 0, SUB = 1, OR = 3;
  localparam logic [31:0] LW = 32'h8C220004, SW = 32'hAC220008, BEQ = 32'h10220003,
                          JAL = 32'h0C000010, ORI = 32'h34220005, JALR = 32'h0040F809,
                          ADDR = 32'h00221820, ILL = 32'hFC000000;

  logic gclk = 1'b1;
  logic rst;
  always #5 gclk = ~gclk;

  mc_ctrl_ws_if #(.ALUOP_W(AW), .CNT_W(CW)) bus ();
  mc_ctrl_ws #(.ALUOP_W(AW), .TIMEOUT(4), .CNT_W(CW)) dut (.clk(gclk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]    st;
    logic [4:0]    we;
    logic          req;
    logic          trap;
    logic [1:0]    tc;
    logic [CW-1:0] ret;
    int            m2r, rdst, pcsrc, aluop;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc_id = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_id, got, exp);
    end
  endtask

  function automatic exp_t E(int st, logic [4:0] we, bit req, int ret,
                             int m2r = -1, int rdst = -1, int pcsrc = -1, int aluop = -1);
    exp_t e;
    e.st = st[3:0]; e.we = we; e.req = req; e.trap = 1'b0; e.tc = 2'b00; e.ret = ret;
    e.m2r = m2r; e.rdst = rdst; e.pcsrc = pcsrc; e.aluop = aluop;
    return e;
  endfunction

  function automatic exp_t T(logic [1:0] tc, int ret);
    exp_t e;
    e = E(15, NO, 1'b0, ret);
    e.trap = 1'b1; e.tc = tc;
    return e;
  endfunction

  task automatic step(input logic [31:0] ins, input logic rdy, input exp_t e);
    bus.instr = ins;
    bus.mem_ready = rdy;
    sb.push_back(e);
    @(posedge gclk);
    #1;
  endtask

  always @(negedge gclk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state", bus.state_o, e.st);
      chk("wr_en", {bus.PCWrite_o, bus.PCWriteCond_o, bus.IRWrite_o, bus.MemWrite_o, bus.RegWrite_o}, e.we);
      chk("mem_req", bus.mem_req, e.req);
      chk("trap", bus.trap_o, e.trap);
      chk("trap_code", bus.trap_code_o, e.tc);
      chk("retired", bus.retired_o, e.ret);
      if (e.m2r >= 0)   chk("MemtoReg", bus.MemtoReg_o, e.m2r);
      if (e.rdst >= 0)  chk("RegDst", bus.RegDst_o, e.rdst);
      if (e.pcsrc >= 0) chk("PCSrc", bus.PCSrc_o, e.pcsrc);
      if (e.aluop >= 0) chk("ALUOp", bus.ALUOp_o, e.aluop);
      cyc_id++;
    end
  end

  initial begin
    rst = 1'b1; bus.instr = '0; bus.mem_ready = 1'b0;
    #1;
    // reset: enables held low even with mem_ready high
    step(LW, 1'b1, E(0, NO, 0, 0));
    step(LW, 1'b0, E(0, NO, 0, 0));
    rst = 1'b0;

    // lw, zero wait states
    step(LW, 1'b1, E(0, PC|IR, 1, 0, -1, -1, -1, ADD));
    step(LW, 1'b1, E(1, NO, 0, 0));
    step(LW, 1'b1, E(2, NO, 0, 0, -1, -1, -1, ADD));
    step(LW, 1'b1, E(3, NO, 1, 0));
    step(LW, 1'b1, E(4, RW, 0, 0, 1, 0));

    // sw with three MEM wait cycles
    step(SW, 1'b1, E(0, PC|IR, 1, 1));
    step(SW, 1'b1, E(1, NO, 0, 1));
    step(SW, 1'b1, E(2, NO, 0, 1));
    for (int i = 0; i < 3; i++) step(SW, 1'b0, E(3, MW, 1, 1));
    step(SW, 1'b1, E(3, MW, 1, 1));

    // beq then jal
    step(BEQ, 1'b1, E(0, PC|IR, 1, 2));
    step(BEQ, 1'b1, E(1, NO, 0, 2));
    step(BEQ, 1'b1, E(7, PCC, 0, 2, -1, -1, 1, SUB));
    step(JAL, 1'b1, E(0, PC|IR, 1, 3));
    step(JAL, 1'b1, E(1, NO, 0, 3));
    step(JAL, 1'b1, E(9, RW, 0, 3, 2, 2));
    step(JAL, 1'b1, E(8, PC, 0, 3, -1, -1, 2));

    // ori (I-type writes rt)
    step(ORI, 1'b1, E(0, PC|IR, 1, 4));
    step(ORI, 1'b1, E(1, NO, 0, 4));
    step(ORI, 1'b1, E(5, NO, 0, 4, -1, -1, -1, OR));
    step(ORI, 1'b1, E(6, RW, 0, 4, 0, 0));

    // jalr: LINK -> EXEC -> JUMP
    step(JALR, 1'b1, E(0, PC|IR, 1, 5));
    step(JALR, 1'b1, E(1, NO, 0, 5));
    step(JALR, 1'b1, E(9, RW, 0, 5, 2, 1));
    step(JALR, 1'b1, E(5, NO, 0, 5, -1, -1, -1, ADD));
    step(JALR, 1'b1, E(8, PC, 0, 5, -1, -1, 1));

    // add aborted by reset in WB_ALU
    step(ADDR, 1'b1, E(0, PC|IR, 1, 6));
    step(ADDR, 1'b1, E(1, NO, 0, 6));
    step(ADDR, 1'b1, E(5, NO, 0, 6, -1, -1, -1, ADD));
    rst = 1'b1;
    step(ADDR, 1'b1, E(0, NO, 0, 0));
    step(ADDR, 1'b1, E(0, NO, 0, 0));
    rst = 1'b0;

    // illegal opcode traps from DECODE, only reset exits
    step(ILL, 1'b1, E(0, PC|IR, 1, 0));
    step(ILL, 1'b1, E(1, NO, 0, 0));
    step(ILL, 1'b1, T(2'b01, 0));
    step(ILL, 1'b1, T(2'b01, 0));
    rst = 1'b1;
    step(ILL, 1'b1, E(0, NO, 0, 0));
    rst = 1'b0;

    // fetch watchdog with TIMEOUT=4: five requesting cycles, then TRAP
    for (int i = 0; i < 5; i++) step(32'h0, 1'b0, E(0, NO, 1, 0));
    step(32'h0, 1'b0, T(2'b10, 0));
    step(32'h0, 1'b1, T(2'b10, 0));

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
